// File: rtl/cnt_seq_checker_if.sv
// ---------------------------------------------------------------------------
// cnt_seq_checker_if
//   Bundles the sample input and the status outputs of cnt_seq_checker.
//   The producer of samples (counter stage or bench) uses the master modport.
//   The checker uses the slave modport.
//
//   vld          sample enable, cnt_in is evaluated only when high
//   cnt_in       3-bit counter value under check
//   locked       high while the checker is in its LOCKED state
//   err          one-cycle pulse after a mismatching accepted sample
//   err_cnt      saturating count of mismatches since reset
//   period_cnt   saturating count of completed error-free periods
//   pos          index (0..14) of the next expected sample
//   exp_val      expected value at pos, 0 while searching
//   last_err_exp expected value at the most recent mismatch
//   last_err_obs observed value at the most recent mismatch
//
//   ERR_W and PER_W must match the parameters of the attached checker.
// ---------------------------------------------------------------------------
interface cnt_seq_checker_if #(
    parameter int ERR_W = 8,
    parameter int PER_W = 8
);
    logic             vld;
    logic [2:0]       cnt_in;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [PER_W-1:0] period_cnt;
    logic [3:0]       pos;
    logic [2:0]       exp_val;
    logic [2:0]       last_err_exp;
    logic [2:0]       last_err_obs;

    modport master (
        output vld, cnt_in,
        input  locked, err, err_cnt, period_cnt, pos, exp_val,
               last_err_exp, last_err_obs
    );

    modport slave (
        input  vld, cnt_in,
        output locked, err, err_cnt, period_cnt, pos, exp_val,
               last_err_exp, last_err_obs
    );
endinterface

// File: rtl/cnt_seq_checker.sv
// ---------------------------------------------------------------------------
// cnt_seq_checker
//   Monitors the output of the 3-bit repeat-4 up/down counter.  The counter
//   has a 15-sample period 0,1,2,3,4,5,6,7,6,5,4,4,3,2,1.  The value 0
//   appears once per period, so the checker synchronises on it.  Every
//   accepted sample is then compared against the expected table.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   SEARCH | waiting for a 0 to synchronise; other samples are ignored
//   TRACK  | synchronised, checking samples, not yet enough good periods
//   LOCKED | LOCK_PERIODS consecutive error-free periods seen
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   cnt_seq_checker_if slave modport (sample in, status out)
//
//   Parameters
//     ERR_W         width of err_cnt (saturating)
//     PER_W         width of period_cnt (saturating)
//     LOCK_PERIODS  consecutive good periods needed for lock (1..15)
// ---------------------------------------------------------------------------
module cnt_seq_checker #(
    parameter int ERR_W        = 8,
    parameter int PER_W        = 8,
    parameter int LOCK_PERIODS = 2
) (
    input  logic               clk,
    input  logic               rst,
    cnt_seq_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        TRACK  = 2'b01,
        LOCKED = 2'b10
    } state_t;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_PERIODS);
    localparam logic [3:0] LAST_POS = 4'd14;

    state_t           state_q, state_d;
    logic [3:0]       pos_q, pos_d;
    logic [3:0]       good_q, good_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [2:0]       exp_q, exp_d;
    logic [2:0]       lexp_q, lexp_d;
    logic [2:0]       lobs_q, lobs_d;

    logic [2:0]       e_cur;
    logic [3:0]       good_inc;

    // Constant ROM of the counter period; indices 15 is unreachable.
    function automatic logic [2:0] exp_rom(input logic [3:0] idx);
        logic [2:0] v;
        case (idx)
            4'd0:    v = 3'd0;
            4'd1:    v = 3'd1;
            4'd2:    v = 3'd2;
            4'd3:    v = 3'd3;
            4'd4:    v = 3'd4;
            4'd5:    v = 3'd5;
            4'd6:    v = 3'd6;
            4'd7:    v = 3'd7;
            4'd8:    v = 3'd6;
            4'd9:    v = 3'd5;
            4'd10:   v = 3'd4;
            4'd11:   v = 3'd4;
            4'd12:   v = 3'd3;
            4'd13:   v = 3'd2;
            4'd14:   v = 3'd1;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            pos_q     <= 4'd0;
            good_q    <= 4'd0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            per_q     <= '0;
            exp_q     <= 3'd0;
            lexp_q    <= 3'd0;
            lobs_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            good_q    <= good_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            per_q     <= per_d;
            exp_q     <= exp_d;
            lexp_q    <= lexp_d;
            lobs_q    <= lobs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        good_d    = good_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        per_d     = per_q;
        lexp_d    = lexp_q;
        lobs_d    = lobs_q;

        e_cur    = exp_rom(pos_q);
        good_inc = (good_q >= LOCK_N) ? LOCK_N : good_q + 4'd1;

        case (state_q)
            SEARCH: begin
                if (bus.vld && bus.cnt_in == 3'd0) begin
                    state_d = TRACK;
                    pos_d   = 4'd1;
                    good_d  = 4'd0;
                end
            end

            TRACK, LOCKED: begin
                if (bus.vld) begin
                    if (bus.cnt_in == e_cur) begin
                        pos_d = (pos_q == LAST_POS) ? 4'd0 : pos_q + 4'd1;
                        if (pos_q == LAST_POS) begin
                            if (per_q != '1)
                                per_d = per_q + 1'b1;
                            good_d = good_inc;
                            if (state_q == TRACK && good_inc == LOCK_N)
                                state_d = LOCKED;
                        end
                    end else begin
                        err_d  = 1'b1;
                        if (err_cnt_q != '1)
                            err_cnt_d = err_cnt_q + 1'b1;
                        lexp_d = e_cur;
                        lobs_d = bus.cnt_in;
                        good_d = 4'd0;
                        // A mismatching 0 is itself a valid period start.
                        if (bus.cnt_in == 3'd0) begin
                            state_d = TRACK;
                            pos_d   = 4'd1;
                        end else begin
                            state_d = SEARCH;
                            pos_d   = 4'd0;
                        end
                    end
                end
            end

            default: begin
                state_d = SEARCH;
                pos_d   = 4'd0;
                good_d  = 4'd0;
            end
        endcase

        exp_d = (state_d == SEARCH) ? 3'd0 : exp_rom(pos_d);
    end

    assign bus.locked       = (state_q == LOCKED);
    assign bus.err          = err_q;
    assign bus.err_cnt      = err_cnt_q;
    assign bus.period_cnt   = per_q;
    assign bus.pos          = pos_q;
    assign bus.exp_val      = exp_q;
    assign bus.last_err_exp = lexp_q;
    assign bus.last_err_obs = lobs_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
module tb_cnt_seq_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnt_seq_checker_if #(.ERR_W(8), .PER_W(8)) bus ();
    cnt_seq_checker_if #(.ERR_W(2), .PER_W(8)) bus2 ();

    cnt_seq_checker #(.ERR_W(8), .PER_W(8), .LOCK_PERIODS(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cnt_seq_checker #(.ERR_W(2), .PER_W(8), .LOCK_PERIODS(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic       vld;
        logic [2:0] cnt;
        logic       e_err;
        logic       e_locked;
        logic [3:0] e_pos;
        logic [2:0] e_exp;
        logic [7:0] e_ecnt;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] seq [15];
    vec_t       tbl [20];
    logic [2:0] pre [12];
    int         ecnt5 [5];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] c);
        bus.vld    = v;
        bus.cnt_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic v, input logic [2:0] c);
        bus2.vld    = v;
        bus2.cnt_in = c;
        @(posedge clk);
        #1;
    endtask

    // Drives n correct samples starting at table index start; with toggle
    // each accepted sample is followed by an idle cycle that must hold.
    task automatic run_stream(input int n, input int start, input bit toggle);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (start + k) % 15;
            step(1'b1, seq[idx]);
            chk("stream_err", int'(bus.err), 0);
            chk("stream_pos", int'(bus.pos), (idx + 1) % 15);
            if (toggle) begin
                step(1'b0, seq[idx]);
                chk("idle_err", int'(bus.err), 0);
                chk("idle_pos", int'(bus.pos), (idx + 1) % 15);
                chk("idle_exp", int'(bus.exp_val), int'(seq[(idx + 1) % 15]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        seq   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                  3'd6, 3'd5, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1};
        pre   = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
                  3'd4, 3'd3, 3'd2, 3'd1};
        ecnt5 = '{1, 2, 3, 3, 3};

        // Out-of-sync prefix, sync, idle hold, mismatch to SEARCH, resync
        // via a mismatching 0.
        for (int i = 0; i < 12; i++)
            tbl[i] = '{1'b1, pre[i], 1'b0, 1'b0, 4'd0, 3'd0, 8'd0};
        tbl[12] = '{1'b1, 3'd0, 1'b0, 1'b0, 4'd1, 3'd1, 8'd0};
        tbl[13] = '{1'b1, 3'd1, 1'b0, 1'b0, 4'd2, 3'd2, 8'd0};
        tbl[14] = '{1'b0, 3'd5, 1'b0, 1'b0, 4'd2, 3'd2, 8'd0};
        tbl[15] = '{1'b1, 3'd2, 1'b0, 1'b0, 4'd3, 3'd3, 8'd0};
        tbl[16] = '{1'b1, 3'd6, 1'b1, 1'b0, 4'd0, 3'd0, 8'd1};
        tbl[17] = '{1'b1, 3'd0, 1'b0, 1'b0, 4'd1, 3'd1, 8'd1};
        tbl[18] = '{1'b1, 3'd0, 1'b1, 1'b0, 4'd1, 3'd1, 8'd2};
        tbl[19] = '{1'b1, 3'd1, 1'b0, 1'b0, 4'd2, 3'd2, 8'd2};

        bus.vld     = 1'b0;
        bus.cnt_in  = 3'd0;
        bus2.vld    = 1'b0;
        bus2.cnt_in = 3'd0;

        // Test 1: reset then 30 correct samples.
        rst = 1'b1;
        step(1'b0, 3'd0);
        step(1'b0, 3'd0);
        rst = 1'b0;
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_pos", int'(bus.pos), 0);
        chk("rst_err_cnt", int'(bus.err_cnt), 0);
        chk("rst_period", int'(bus.period_cnt), 0);
        chk("rst_exp", int'(bus.exp_val), 0);
        chk("rst_err", int'(bus.err), 0);
        run_stream(29, 0, 1'b0);
        chk("t1_not_yet_locked", int'(bus.locked), 0);
        chk("t1_period_1", int'(bus.period_cnt), 1);
        run_stream(1, 14, 1'b0);
        chk("t1_locked", int'(bus.locked), 1);
        chk("t1_period", int'(bus.period_cnt), 2);
        chk("t1_err_cnt", int'(bus.err_cnt), 0);
        chk("t1_pos", int'(bus.pos), 0);

        // Test 2: corrupt the second 4, recover and relock.
        run_stream(11, 0, 1'b0);
        step(1'b1, 3'd5);
        chk("t2_err", int'(bus.err), 1);
        chk("t2_err_cnt", int'(bus.err_cnt), 1);
        chk("t2_last_exp", int'(bus.last_err_exp), 4);
        chk("t2_last_obs", int'(bus.last_err_obs), 5);
        chk("t2_unlocked", int'(bus.locked), 0);
        chk("t2_pos_search", int'(bus.pos), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq[12 + i]);
            chk("t2_ignored_err", int'(bus.err), 0);
            chk("t2_ignored_pos", int'(bus.pos), 0);
            chk("t2_ignored_exp", int'(bus.exp_val), 0);
        end
        run_stream(29, 0, 1'b0);
        chk("t2_not_yet_relocked", int'(bus.locked), 0);
        run_stream(1, 14, 1'b0);
        chk("t2_relocked", int'(bus.locked), 1);
        chk("t2_period", int'(bus.period_cnt), 4);
        chk("t2_err_cnt_hold", int'(bus.err_cnt), 1);

        // Test 6: reset while locked at pos 7.
        run_stream(7, 0, 1'b0);
        chk("t6_pre_pos", int'(bus.pos), 7);
        chk("t6_pre_locked", int'(bus.locked), 1);
        rst = 1'b1;
        step(1'b1, 3'd7);
        rst = 1'b0;
        chk("t6_locked", int'(bus.locked), 0);
        chk("t6_err_cnt", int'(bus.err_cnt), 0);
        chk("t6_period", int'(bus.period_cnt), 0);
        chk("t6_pos", int'(bus.pos), 0);
        chk("t6_last_obs", int'(bus.last_err_obs), 0);
        step(1'b1, 3'd5);
        chk("t6_ign_err", int'(bus.err), 0);
        chk("t6_ign_pos", int'(bus.pos), 0);
        chk("t6_ign_exp", int'(bus.exp_val), 0);
        step(1'b1, 3'd0);
        chk("t6_sync_pos", int'(bus.pos), 1);
        chk("t6_sync_exp", int'(bus.exp_val), 1);

        // Test 3: table-driven vectors from a fresh reset.
        rst = 1'b1;
        step(1'b0, 3'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].vld, tbl[i].cnt);
            chk($sformatf("t3_err[%0d]", i), int'(bus.err), int'(tbl[i].e_err));
            chk($sformatf("t3_locked[%0d]", i), int'(bus.locked), int'(tbl[i].e_locked));
            chk($sformatf("t3_pos[%0d]", i), int'(bus.pos), int'(tbl[i].e_pos));
            chk($sformatf("t3_exp[%0d]", i), int'(bus.exp_val), int'(tbl[i].e_exp));
            chk($sformatf("t3_ecnt[%0d]", i), int'(bus.err_cnt), int'(tbl[i].e_ecnt));
        end
        chk("t3_last_exp", int'(bus.last_err_exp), 1);
        chk("t3_last_obs", int'(bus.last_err_obs), 0);

        // Test 4: vld toggling every cycle.
        rst = 1'b1;
        step(1'b0, 3'd0);
        step(1'b0, 3'd0);
        rst = 1'b0;
        run_stream(30, 0, 1'b1);
        chk("t4_locked", int'(bus.locked), 1);
        chk("t4_period", int'(bus.period_cnt), 2);
        chk("t4_err_cnt", int'(bus.err_cnt), 0);
        chk("t4_pos", int'(bus.pos), 0);
        bus.vld = 1'b0;

        // Test 5: 2-bit error counter saturation on the second instance.
        for (int i = 0; i < 5; i++) begin
            step2(1'b1, 3'd0);
            chk("t5_sync_err", int'(bus2.err), 0);
            chk("t5_sync_pos", int'(bus2.pos), 1);
            step2(1'b1, 3'd3);
            chk("t5_err", int'(bus2.err), 1);
            chk("t5_err_cnt", int'(bus2.err_cnt), ecnt5[i]);
        end
        step2(1'b1, 3'd0);
        chk("t5_final_err", int'(bus2.err), 0);
        chk("t5_final_pos", int'(bus2.pos), 1);
        chk("t5_final_cnt", int'(bus2.err_cnt), 3);
        bus2.vld = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
